// File: rtl/pipe_sink_fifo.sv
// Sink for the add/AND pipeline output: small FWFT FIFO with valid/ready
// drain, saturating overflow drop counter and running sum of accepted words.
module pipe_sink_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [CNT_W-1:0]           drop_count,
    output logic [WIDTH-1:0]           sum
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [CW-1:0]    countQ;
    logic [CNT_W-1:0] dropCountQ;
    logic [WIDTH-1:0] sumQ;

    logic push;
    logic pop;
    logic drop;

    // Status and head word come from registered state only.
    always_comb begin
        empty     = (countQ == '0);
        full      = (countQ == DEPTH_C);
        out_valid = !empty;
        out_data  = empty ? '0 : mem[rdPtr];
        count     = countQ;
        drop_count = dropCountQ;
        sum       = sumQ;
    end

    always_comb begin
        pop  = out_valid && out_ready;
        push = in_valid && (!full || pop);
        drop = in_valid && full && !pop;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wrPtr] <= in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            countQ <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !pop) begin
                countQ <= countQ + 1'b1;
            end else if (pop && !push) begin
                countQ <= countQ - 1'b1;
            end
        end
    end

    // clr takes priority over a same-cycle drop or push on the statistics.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dropCountQ <= '0;
            sumQ       <= '0;
        end else if (clr) begin
            dropCountQ <= '0;
            sumQ       <= '0;
        end else begin
            if (drop && (dropCountQ != '1)) begin
                dropCountQ <= dropCountQ + 1'b1;
            end
            if (push) begin
                sumQ <= sumQ + in_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (countQ <= DEPTH_C);
            assert (!(full && empty));
            assert (out_valid == !empty);
            assert (!empty || (out_data == '0));
        end
    end

endmodule

// File: doc/pipe_sink_fifo.md
Name: pipe_sink_fifo

Overview:
- Downstream consumer of the two-stage add/AND pipeline's dataOut stream.
- Captures valid result words into a small first-word-fall-through FIFO and presents them through a valid/ready interface.
- Keeps a drop counter and a running sum of accepted words so formal and simulation checks can cross-check the pipeline output.
- Purely sequential buffering stage; no arithmetic on the data path beyond the sum.

Parameters:
- WIDTH, 32, data word width; matches pipeline dataOut.
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- CNT_W, 16, drop counter width.

Ports:
- clock  input  1  single clock, posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- clr  input  1  synchronous clear of drop_count and sum only; FIFO contents untouched.
- in_data  input  WIDTH  word from pipeline dataOut.
- in_valid  input  1  in_data is a valid result this cycle.
- out_data  output  WIDTH  head-of-FIFO word; 0 when empty.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- count  output  clog2(DEPTH)+1  number of stored words, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- drop_count  output  CNT_W  words lost to overflow; saturating.
- sum  output  WIDTH  modulo-2^WIDTH sum of all accepted words since reset/clr.

Behaviour:
- Reset (asynchronous, takes effect immediately regardless of clock):
  - wr_ptr = rd_ptr = 0, count = 0, drop_count = 0, sum = 0.
  - Outputs: out_valid = 0, out_data = 0, full = 0, empty = 1.
  - Memory contents need no reset; out_data is forced to 0 while empty.
- Reset mid-operation:
  - All stored words are discarded.
  - After reset deasserts, the first clock edge behaves as from the empty state.
- Pop: pop = out_valid && out_ready.
- Push:
  - push = in_valid && (!full || pop).
  - Writing into a full FIFO is allowed when a pop occurs in the same cycle.
- Drop: drop = in_valid && full && !pop.
  - Word discarded.
  - drop_count increments by 1, saturating at 2^CNT_W-1 (no wrap).
- Pointers:
  - log2(DEPTH)-bit, wrap naturally from DEPTH-1 to 0.
  - count next = count + push - pop.
  - Push and pop together leave count unchanged.
- FWFT latency:
  - Word pushed at edge N appears on out_data/out_valid immediately after edge N when the FIFO was empty.
  - Otherwise it appears after all older words.
  - out_data/out_valid/full/empty are decoded from registered state only; no combinational path from in_* to out_*.
- out_ready while empty: ignored; no pointer movement.
- Sum:
  - sum_next = sum + in_data on push, truncated to WIDTH.
  - Dropped words are not summed.
- clr:
  - Zeroes drop_count and sum at the edge.
  - If push or drop happens in the same cycle, clr wins: the result is 0, and the FIFO still stores the pushed word.
- Ordering: strict FIFO order; no reordering or duplication.
- Invariants (assertable):
  - count <= DEPTH.
  - full implies !empty.
  - out_valid == !empty.
  - When empty, out_data == 0.

Test Plan:
- Reset then idle: hold in_valid=0 for 5 cycles -> empty=1, count=0, out_valid=0, out_data=0, sum=0, drop_count=0.
- Single pass-through: push 0x0000_0005 with out_ready=0 -> next cycle out_valid=1, out_data=5, count=1, sum=5. Then out_ready=1 for one cycle -> empty=1.
- Fill and overflow: out_ready=0, push 1,2,3,4,5,6 on consecutive cycles -> full=1 after the 4th push, drop_count=2, sum=10. Drain -> out_data sequence 1,2,3,4.
- Full with simultaneous pop: FIFO holds 1..4, in_valid=1 with 9, out_ready=1 -> 1 popped, 9 stored, count stays 4, drop_count unchanged, sum += 9. Drain order 2,3,4,9.
- Sum wrap and clr: push 0xFFFF_FFFF then 0x0000_0002 -> sum=0x0000_0001. Assert clr in the same cycle as a push of 7 -> sum=0, 7 stored in FIFO.
- Async reset mid-burst: FIFO holds 3 words, drop_count=1; assert reset between edges -> outputs clear immediately without a clock edge. After release, push 0xA -> out_data=0xA, count=1.
